// File: rtl/breath_pkg.sv
// Shared types and default level constants for the breathing-LED chain
// (also consumed by the downstream PWM stage).
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    UP       = 2'd0,
    HOLD_TOP = 2'd1,
    DOWN     = 2'd2,
    HOLD_BOT = 2'd3
  } ramp_e;

  localparam int unsigned LVL_W_DEF   = 8;
  localparam int unsigned LVL_MAX_DEF = 255;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/breath_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-window debounce,
// one-cycle pulse on each debounced press (1->0). Releases give no pulse.
module key_debounce #(
  parameter int unsigned DB_CNT = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_CNT + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CNT - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      // edge taken on the registered debounced level, one cycle after it settles
      press_q  <= db_dly_q & ~db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/breath_ctrl.sv
// Mode cycling and triangular brightness ramp feeding the PWM stage.
// Define BREATH_CTRL_HOLD_EN to dwell HOLD_TICKS ramp steps at each extreme.
module breath_ctrl
  import breath_pkg::*;
#(
  parameter int unsigned DB_CNT     = 240000,
  parameter int unsigned LVL_W      = LVL_W_DEF,
  parameter int unsigned LVL_MAX    = LVL_MAX_DEF,
  parameter int unsigned DIV_SLOW   = 47000,
  parameter int unsigned DIV_FAST   = 11750,
  parameter int unsigned HOLD_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  output logic [LVL_W-1:0] level,
  output logic             level_vld,
  output logic [1:0]       mode
);

  localparam int unsigned DIV_BIG = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned PW      = $clog2(DIV_BIG + 1);
  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(LVL_MAX);

  if (LVL_MAX < 2 || LVL_MAX > (2 ** LVL_W) - 1 || DIV_SLOW < 1 || DIV_FAST < 1 ||
      HOLD_TICKS < 1) begin : g_param_chk
    $error("breath_ctrl: illegal parameter set");
  end

`ifdef BREATH_CTRL_HOLD_EN
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam ramp_e AFTER_TOP = HOLD_TOP;
  localparam ramp_e AFTER_BOT = HOLD_BOT;
  logic [HW-1:0] hold_q, hold_d;
`else
  localparam ramp_e AFTER_TOP = DOWN;
  localparam ramp_e AFTER_BOT = UP;
`endif

  mode_e            mode_q, mode_d;
  ramp_e            ramp_q, ramp_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             vld_q, vld_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [PW-1:0]    div_last;
  logic             press, run, tick;

  key_debounce #(.DB_CNT(DB_CNT)) u_key (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n),
    .press_o (press)
  );

  assign run      = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
  assign div_last = (mode_q == MODE_FAST) ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);
  assign tick     = run && (presc_q == div_last);

  always_comb begin
    mode_d  = mode_q;
    ramp_d  = ramp_q;
    level_d = level_q;
    vld_d   = 1'b0;
    presc_d = presc_q;
`ifdef BREATH_CTRL_HOLD_EN
    hold_d  = hold_q;
`endif
    // a press outranks a coincident tick: the tick is simply dropped
    if (press) begin
      mode_d  = next_mode(mode_q);
      presc_d = '0;
      ramp_d  = UP;
      level_d = (mode_d == MODE_ON) ? LVL_TOP : '0;
      vld_d   = 1'b1;
`ifdef BREATH_CTRL_HOLD_EN
      hold_d  = '0;
`endif
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        unique case (ramp_q)
          UP: begin
            if (level_q < LVL_TOP) begin
              level_d = level_q + LVL_W'(1);
              vld_d   = 1'b1;
            end
            if (level_q >= LVL_TOP - LVL_W'(1)) ramp_d = AFTER_TOP;
          end
          DOWN: begin
            if (level_q != '0) begin
              level_d = level_q - LVL_W'(1);
              vld_d   = 1'b1;
            end
            if (level_q <= LVL_W'(1)) ramp_d = AFTER_BOT;
          end
`ifdef BREATH_CTRL_HOLD_EN
          HOLD_TOP: begin
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
              hold_d = '0;
              ramp_d = DOWN;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          HOLD_BOT: begin
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
              hold_d = '0;
              ramp_d = UP;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
`endif
          default: ramp_d = UP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_SLOW;
      ramp_q  <= UP;
      level_q <= '0;
      vld_q   <= 1'b0;
      presc_q <= '0;
`ifdef BREATH_CTRL_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      ramp_q  <= ramp_d;
      level_q <= level_d;
      vld_q   <= vld_d;
      presc_q <= presc_d;
`ifdef BREATH_CTRL_HOLD_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign level     = level_q;
  assign level_vld = vld_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_breath_ctrl.sv
// Scoreboard bench for breath_ctrl: random key activity against a
// table-driven breath model; honours BREATH_CTRL_HOLD_EN like the design.
module tb_breath_ctrl;

  localparam int unsigned DB   = 8;
  localparam int unsigned DS   = 4;
  localparam int unsigned DF   = 2;
  localparam int unsigned LMAX = 5;
  localparam int unsigned HT   = 2;
  localparam int unsigned LW   = 8;
`ifdef BREATH_CTRL_HOLD_EN
  localparam int HOLDN = HT;
`else
  localparam int HOLDN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          key_n;
  logic [LW-1:0] level;
  logic          level_vld;
  logic [1:0]    mode;

  always #5 clk = ~clk;

  breath_ctrl #(
    .DB_CNT     (DB),
    .LVL_W      (LW),
    .LVL_MAX    (LMAX),
    .DIV_SLOW   (DS),
    .DIV_FAST   (DF),
    .HOLD_TICKS (HT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .level     (level),
    .level_vld (level_vld),
    .mode      (mode)
  );

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic [1:0]    md;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: one full breath as a table of per-tick levels.
  int seq[$];
  int m_mode, m_level, m_cnt, m_phase, m_run, m_pend;
  bit m_db, m_kd0, m_kd1;

  task automatic build_seq();
    seq.delete();
    for (int i = 1; i <= int'(LMAX); i++) seq.push_back(i);
    for (int i = 0; i < HOLDN; i++) seq.push_back(LMAX);
    for (int i = int'(LMAX) - 1; i >= 0; i--) seq.push_back(i);
    for (int i = 0; i < HOLDN; i++) seq.push_back(0);
  endtask

  task automatic model_reset();
    m_mode  = 1;
    m_level = 0;
    m_cnt   = 0;
    m_phase = 0;
    m_run   = 0;
    m_pend  = 0;
    m_db    = 1'b1;
    m_kd0   = 1'b1;
    m_kd1   = 1'b1;
    sbq.delete();
  endtask

  task automatic push_exp();
    exp_t e;
    e.lvl = m_level[LW-1:0];
    e.md  = m_mode[1:0];
    sbq.push_back(e);
  endtask

  // k = key_n value sampled on this clock edge
  task automatic model_edge(input bit k);
    bit sync;
    bit change;
    change = 1'b0;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) change = 1'b1;
    end
    sync = m_kd1;
    if (sync != m_db) begin
      m_run++;
      if (m_run == int'(DB)) begin
        m_db  = sync;
        m_run = 0;
        if (!sync) m_pend = 2;
      end
    end else begin
      m_run = 0;
    end
    m_kd1 = m_kd0;
    m_kd0 = k;
    if (change) begin
      m_mode  = (m_mode + 1) % 4;
      m_cnt   = 0;
      m_phase = 0;
      m_level = (m_mode == 3) ? int'(LMAX) : 0;
      push_exp();
    end else if (m_mode == 1 || m_mode == 2) begin
      m_cnt++;
      if (m_cnt == ((m_mode == 1) ? int'(DS) : int'(DF))) begin
        m_cnt = 0;
        if (seq[m_phase] != m_level) begin
          m_level = seq[m_phase];
          push_exp();
        end
        m_phase = (m_phase + 1) % seq.size();
      end
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every update strobe and tracks steady state.
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [LW-1:0] el;
    logic [1:0]    em;
    if (rst === 1'b1) begin
      if (level_vld === 1'b1) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_update: level=%0d mode=%0d, expected no update", level, mode);
        end else begin
          e = sbq.pop_front();
          if (level !== e.lvl || mode !== e.md) begin
            n_err++;
            $display("FAIL update: level=%0d mode=%0d, expected level=%0d mode=%0d",
                     level, mode, e.lvl, e.md);
          end
        end
      end
      el = m_level[LW-1:0];
      em = m_mode[1:0];
      n_vec++;
      if (level !== el || mode !== em) begin
        n_err++;
        $display("FAIL state: level=%0d mode=%0d, expected level=%0d mode=%0d",
                 level, mode, el, em);
      end
    end
  end

  task automatic step(input bit k);
    key_n = k;
    @(posedge clk);
    model_edge(k);
    #1;
  endtask

  task automatic hold_key(input bit k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    check("queue_empty_before_reset", sbq.size(), 0);
    rst   = 1'b0;
    key_n = 1'b1;
    model_reset();
    #1;
    check("reset_level", int'(level), 0);
    check("reset_vld", int'(level_vld), 0);
    check("reset_mode", int'(mode), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    key_n = 1'b1;
    build_seq();
    model_reset();
    apply_reset();

    hold_key(1'b1, 60);                 // free-running SLOW breath
    hold_key(1'b0, DB - 1);             // glitch one cycle short of the window
    hold_key(1'b1, 30);
    hold_key(1'b0, 20);                 // press -> FAST
    hold_key(1'b1, 40);
    for (int i = 0; i < 3; i++) begin   // ON, OFF, back to SLOW
      hold_key(1'b0, 12);
      hold_key(1'b1, 30);
    end

    apply_reset();                      // press lands on the third SLOW tick
    hold_key(1'b0, 12);
    hold_key(1'b1, 30);

    hold_key(1'b1, 17);                 // reset while mid-ramp
    apply_reset();
    hold_key(1'b1, 30);

    for (int i = 0; i < 60; i++) begin
      hold_key(1'b0, int'($urandom_range(1, 3 * DB)));
      hold_key(1'b1, int'($urandom_range(1, 70)));
      if (i == 30) apply_reset();
    end
    hold_key(1'b1, 60);

    @(negedge clk);
    #1;
    check("queue_empty_at_end", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/breath_ctrl.md
# breath_ctrl

Mode and brightness-level generator that sits directly upstream of the breathing-LED PWM stage. Debounces one raw push button, cycles through four lighting modes, and produces a triangular brightness ramp. The ramp is emitted as a level word plus a one-cycle update strobe, which the PWM stage compares against its own carrier counter. All logic runs in the 12 MHz board clock domain.

## Interface
- DB_CNT, 240000, debounce stability window in clk cycles (20 ms at 12 MHz)
- LVL_W, 8, width of level
- LVL_MAX, 255, ramp peak value (≤ 2^LVL_W−1, ≥ 2)
- DIV_SLOW, 47000, clk cycles per ramp step in SLOW mode (~2 s full breath)
- DIV_FAST, 11750, clk cycles per ramp step in FAST mode
- HOLD_TICKS, 16, ramp steps spent at each extreme (hold feature only)
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- key_n  in  1  raw push button, active-low, asynchronous to clk
- level  out  LVL_W  brightness level to PWM stage
- level_vld  out  1  one-cycle pulse whenever level is (re)written
- mode  out  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON

## Operation
- Reset values:
  - level = 0, level_vld = 0, mode = 1 (SLOW)
  - ramp state UP; prescaler, debounce and hold counters 0
  - debounced key = 1 (released)
- Key path:
  - key_n passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized key differs from the debounced state, and clears to 0 on any match.
  - When the counter is at DB_CNT−1 and a mismatch is present, the debounced state takes the synchronized value and the counter clears.
  - A debounced 1→0 transition registers a one-cycle press pulse.
  - Release is debounced identically and generates no pulse.
- Mode: each press pulse advances mode by 1, wrapping 3→0.
- Mode change, same cycle mode updates:
  - prescaler cleared; ramp state forced to UP (OFF/ON: parked)
  - level loaded: 0 for OFF, SLOW and FAST; LVL_MAX for ON
  - level_vld pulses
- Prescaler (SLOW/FAST only):
  - counts 0..DIV−1, where DIV is the value for the current mode
  - tick on the cycle count == DIV−1, then wraps to 0
  - frozen at 0 in OFF/ON
- Ramp FSM, advances on tick only:
  - UP: level+1; on reaching LVL_MAX → HOLD_TOP (DOWN if hold compiled out).
  - HOLD_TOP: hold counter counts HOLD_TICKS ticks, then → DOWN, counter cleared.
  - DOWN: level−1; on reaching 0 → HOLD_BOT (UP if no hold).
  - HOLD_BOT: HOLD_TICKS ticks, then → UP.
- level_vld pulses only on ticks that change level, plus on mode changes; never during holds.
- level never exceeds LVL_MAX and never underflows below 0. Arithmetic is unsigned LVL_W-bit with no wrap.
- Simultaneous press pulse and tick: the mode change wins and the tick is discarded.
- Reset asserted mid-ramp: all registers return to reset values immediately (asynchronous). The first step after release is level 1, DIV_SLOW cycles later.

## Timing
- key_n held low continuously from the first sampling edge E0: mode updates on edge E0+DB_CNT+3.
- Any glitch shorter than DB_CNT cycles produces no mode change.
- level and level_vld are registered and change on the same edge.
- SLOW full cycle with hold: 2·(LVL_MAX+HOLD_TICKS)·DIV_SLOW clocks.

## Configuration
- BREATH_CTRL_HOLD_EN defined:
  - HOLD_TOP/HOLD_BOT states and the hold counter are present.
  - The ramp dwells for HOLD_TICKS ticks at each extreme.
- Undefined:
  - No hold states and no hold counter.
  - The ramp reverses on the tick immediately after reaching LVL_MAX or 0.
  - Period is 2·LVL_MAX·DIV.

## Structure
- Shared package breath_pkg:
  - mode enum with MODE_OFF=0, MODE_SLOW=1, MODE_FAST=2, MODE_ON=3
  - ramp state enum: UP, HOLD_TOP, DOWN, HOLD_BOT
  - default LVL_W and LVL_MAX constants, also used by the PWM stage
- Sub-module key_debounce: synchronizer, debounce counter, press pulse. Parameterized by DB_CNT.

## Test plan
Benches use DB_CNT=8, DIV_SLOW=4, DIV_FAST=2, LVL_MAX=5, HOLD_TICKS=2, hold enabled unless stated.
- Release reset, no key → level 0 at reset; level 1 with level_vld after 4 clocks; level 5 after 20 clocks; level holds 8 clocks; then falls to 0.
- key_n low 7 clocks then high → mode stays 1, no level_vld outside ramp ticks.
- key_n low 20 clocks → mode 2 on edge E0+11, level 0 with level_vld; subsequent steps every 2 clocks.
- Three further presses → mode 3 with level 5; then mode 0 with level 0; then mode 1. No ramp activity in modes 0 and 3.
- Press pulse aligned with a tick → only the mode-change update occurs; the level does not also step.
- Hold compiled out, SLOW → level sequence 0,1..5,4..0,1 with no repeated value; period 40 clocks.
